// File: rtl/ddr4_pattern_tester_if.sv
// ============================================================================
// ddr4_pattern_tester_if : AXI4 master/slave bundle used by the DDR4 pattern tester
// Rev 1.0
// ============================================================================
`default_nettype none

interface ddr4_pattern_tester_if #(
  parameter int ADDR_W = 64,
  parameter int ID_W   = 1
);
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic [ID_W-1:0]   awid;
  logic [3:0]        awcache;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;

  logic [127:0]      wdata;
  logic [15:0]       wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [ID_W-1:0]   arid;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;

  logic [127:0]      rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awlen, awsize, awburst, awid, awcache, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arlen, arsize, arburst, arid, arcache, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awid, awcache, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arlen, arsize, arburst, arid, arcache, arprot, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

`default_nettype wire

// File: rtl/ddr4_pattern_tester.sv
// ============================================================================
// ddr4_pattern_tester : AXI4 write-then-read-back address-pattern memory tester
// Rev 1.0
// ============================================================================
`default_nettype none

module ddr4_pattern_tester #(
  parameter int ADDR_W    = 64,
  parameter int BURST_LEN = 16,
  parameter int ID_W      = 1
) (
  input  wire logic              ACLK,
  input  wire logic              ARESETN,
  input  wire logic              START,
  input  wire logic [ADDR_W-1:0] BASE_ADDR,
  input  wire logic [15:0]       NUM_BURSTS,
  input  wire logic [31:0]       SEED,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   PASS,
  output logic [15:0]            ERR_COUNT,
  output logic [ADDR_W-1:0]      FAIL_ADDR,
  output logic                   RESP_ERR,
  ddr4_pattern_tester_if.master  M_AXI
);

  localparam int                BURST_BYTES  = BURST_LEN * 16;
  localparam logic [7:0]        LAST_BEAT    = 8'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] BURST_STRIDE = ADDR_W'(BURST_BYTES);
  localparam logic [ADDR_W-1:0] OFFS_MASK    = ADDR_W'(BURST_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_ADDR = 3'd1,
    S_WR_DATA = 3'd2,
    S_WR_RESP = 3'd3,
    S_RD_ADDR = 3'd4,
    S_RD_DATA = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  // Lane i of the beat at byte address a carries (a + 4*i) ^ seed.
  function automatic logic [127:0] beat_pattern(input logic [31:0] a, input logic [31:0] s);
    logic [127:0] p;
    p = '0;
    for (int i = 0; i < 4; i++) begin
      p[32*i +: 32] = (a + 32'(4 * i)) ^ s;
    end
    return p;
  endfunction

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] burst_addr_q, burst_addr_d;
  logic [7:0]        beat_q, beat_d;
  logic [15:0]       burst_cnt_q, burst_cnt_d;
  logic [15:0]       num_bursts_q, num_bursts_d;
  logic [31:0]       seed_q, seed_d;
  logic [15:0]       err_count_q, err_count_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic              resp_err_q, resp_err_d;
  logic              awvalid_q, awvalid_d;
  logic              arvalid_q, arvalid_d;
  logic              wvalid_q, wvalid_d;

  logic [ADDR_W-1:0] beat_addr;
  logic [127:0]      expected;
  logic              last_burst;

  assign beat_addr  = burst_addr_q + ADDR_W'({beat_q, 4'b0000});
  assign expected   = beat_pattern(beat_addr[31:0], seed_q);
  assign last_burst = (burst_cnt_q == num_bursts_q - 16'd1);

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    burst_addr_d = burst_addr_q;
    beat_d       = beat_q;
    burst_cnt_d  = burst_cnt_q;
    num_bursts_d = num_bursts_q;
    seed_d       = seed_q;
    err_count_d  = err_count_q;
    fail_addr_d  = fail_addr_q;
    resp_err_d   = resp_err_q;
    awvalid_d    = awvalid_q;
    arvalid_d    = arvalid_q;
    wvalid_d     = wvalid_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          base_d       = BASE_ADDR & ~OFFS_MASK;
          burst_addr_d = BASE_ADDR & ~OFFS_MASK;
          num_bursts_d = NUM_BURSTS;
          seed_d       = SEED;
          beat_d       = '0;
          burst_cnt_d  = '0;
          err_count_d  = '0;
          fail_addr_d  = '0;
          resp_err_d   = 1'b0;
          state_d      = (NUM_BURSTS == 16'd0) ? S_DONE : S_WR_ADDR;
        end
      end

      // VALID rises one cycle after entry and drops on the handshake.
      S_WR_ADDR: begin
        if (awvalid_q && M_AXI.awready) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b1;
          state_d   = S_WR_DATA;
        end else begin
          awvalid_d = 1'b1;
        end
      end

      S_WR_DATA: begin
        if (wvalid_q && M_AXI.wready) begin
          if (beat_q == LAST_BEAT) begin
            beat_d   = '0;
            wvalid_d = 1'b0;
            state_d  = S_WR_RESP;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end

      S_WR_RESP: begin
        if (M_AXI.bvalid) begin
          if (M_AXI.bresp != 2'b00) resp_err_d = 1'b1;
          if (last_burst) begin
            burst_cnt_d  = '0;
            burst_addr_d = base_q;
            state_d      = S_RD_ADDR;
          end else begin
            burst_cnt_d  = burst_cnt_q + 16'd1;
            burst_addr_d = burst_addr_q + BURST_STRIDE;
            state_d      = S_WR_ADDR;
          end
        end
      end

      S_RD_ADDR: begin
        if (arvalid_q && M_AXI.arready) begin
          arvalid_d = 1'b0;
          state_d   = S_RD_DATA;
        end else begin
          arvalid_d = 1'b1;
        end
      end

      // Burst exit follows the local beat count; RLAST is deliberately ignored.
      S_RD_DATA: begin
        if (M_AXI.rvalid) begin
          if (M_AXI.rresp != 2'b00) resp_err_d = 1'b1;
          if (M_AXI.rdata != expected) begin
            if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
            if (err_count_q == 16'd0)    fail_addr_d = beat_addr;
          end
          if (beat_q == LAST_BEAT) begin
            beat_d = '0;
            if (last_burst) begin
              state_d = S_DONE;
            end else begin
              burst_cnt_d  = burst_cnt_q + 16'd1;
              burst_addr_d = burst_addr_q + BURST_STRIDE;
              state_d      = S_RD_ADDR;
            end
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      burst_addr_q <= '0;
      beat_q       <= '0;
      burst_cnt_q  <= '0;
      num_bursts_q <= '0;
      seed_q       <= '0;
      err_count_q  <= '0;
      fail_addr_q  <= '0;
      resp_err_q   <= 1'b0;
      awvalid_q    <= 1'b0;
      arvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      burst_addr_q <= burst_addr_d;
      beat_q       <= beat_d;
      burst_cnt_q  <= burst_cnt_d;
      num_bursts_q <= num_bursts_d;
      seed_q       <= seed_d;
      err_count_q  <= err_count_d;
      fail_addr_q  <= fail_addr_d;
      resp_err_q   <= resp_err_d;
      awvalid_q    <= awvalid_d;
      arvalid_q    <= arvalid_d;
      wvalid_q     <= wvalid_d;
    end
  end

  assign BUSY      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign DONE      = (state_q == S_DONE);
  assign PASS      = DONE && (err_count_q == 16'd0) && !resp_err_q;
  assign ERR_COUNT = err_count_q;
  assign FAIL_ADDR = fail_addr_q;
  assign RESP_ERR  = resp_err_q;

  assign M_AXI.awaddr  = burst_addr_q;
  assign M_AXI.awlen   = LAST_BEAT;
  assign M_AXI.awsize  = 3'b100;
  assign M_AXI.awburst = 2'b01;
  assign M_AXI.awid    = {ID_W{1'b0}};
  assign M_AXI.awcache = 4'd0;
  assign M_AXI.awprot  = 3'd0;
  assign M_AXI.awvalid = awvalid_q;

  assign M_AXI.wdata   = expected;
  assign M_AXI.wstrb   = 16'hFFFF;
  assign M_AXI.wlast   = (beat_q == LAST_BEAT);
  assign M_AXI.wvalid  = wvalid_q;

  assign M_AXI.bready  = (state_q == S_WR_RESP);

  assign M_AXI.araddr  = burst_addr_q;
  assign M_AXI.arlen   = LAST_BEAT;
  assign M_AXI.arsize  = 3'b100;
  assign M_AXI.arburst = 2'b01;
  assign M_AXI.arid    = {ID_W{1'b0}};
  assign M_AXI.arcache = 4'd0;
  assign M_AXI.arprot  = 3'd0;
  assign M_AXI.arvalid = arvalid_q;

  assign M_AXI.rready  = (state_q == S_RD_DATA);

endmodule

`default_nettype wire

// File: tb/tb_ddr4_pattern_tester.sv
// ============================================================================
// tb_ddr4_pattern_tester : randomized bench with a reference AXI memory slave
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ddr4_pattern_tester;

  localparam int ADDR_W    = 64;
  localparam int BURST_LEN = 16;
  localparam int BB        = BURST_LEN * 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [63:0]       base_addr = '0;
  logic [15:0]       num_bursts = '0;
  logic [31:0]       seed = '0;
  logic              busy, done, pass, resp_err;
  logic [15:0]       err_count;
  logic [63:0]       fail_addr;

  always #5 clk = ~clk;

  ddr4_pattern_tester_if #(.ADDR_W(ADDR_W), .ID_W(1)) axi ();

  ddr4_pattern_tester #(.ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN), .ID_W(1)) dut (
    .ACLK      (clk),
    .ARESETN   (rst_n),
    .START     (start),
    .BASE_ADDR (base_addr),
    .NUM_BURSTS(num_bursts),
    .SEED      (seed),
    .BUSY      (busy),
    .DONE      (done),
    .PASS      (pass),
    .ERR_COUNT (err_count),
    .FAIL_ADDR (fail_addr),
    .RESP_ERR  (resp_err),
    .M_AXI     (axi)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] model_beat(input logic [63:0] a, input logic [31:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = (a[31:0] + 32'(4 * i)) ^ s;
    return r;
  endfunction

  // Run configuration shared with the slave model
  logic [63:0] cfg_base    = '0;
  logic [31:0] cfg_seed    = '0;
  bit          cfg_bp      = 1'b0;
  logic [63:0] cfg_corrupt = '1;
  int          cfg_slverr  = -1;

  // Slave-side bookkeeping
  logic [127:0] mem [logic [63:0]];
  int           cyc = 0;
  int           aw_n = 0, ar_n = 0, r_beats = 0, w_burst_idx = 0, last_r_cyc = 0;
  bit           w_open = 0, b_pend = 0, r_open = 0, r_hs = 0, prev_wstall = 0, first_seen = 0;
  logic [63:0]  w_addr = '0, r_addr = '0;
  int           w_beat = 0, r_beat = 0;
  logic [1:0]   b_resp = '0;
  logic [127:0] prev_wdata = '0, first_wdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Everything is decided at the falling edge; a VALID&&READY seen here
  // completes at the following rising edge.
  initial begin
    logic [63:0]  a;
    logic [127:0] d;
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0;
    axi.arready = 0; axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0; axi.rlast = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        w_open = 0; b_pend = 0; r_open = 0; r_hs = 0; prev_wstall = 0;
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.arready = 0; axi.rvalid = 0;
        continue;
      end
      axi.bvalid = b_pend;
      axi.bresp  = b_resp;
      if (axi.bvalid && axi.bready) b_pend = 0;

      if (prev_wstall) check_eq("wdata_hold", axi.wdata, prev_wdata);
      axi.wready = cfg_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (axi.wvalid) check_eq("w_after_aw", w_open, 1'b1);
      if (axi.wvalid && axi.wready && w_open) begin
        a = w_addr + 64'(w_beat * 16);
        check_eq("wdata", axi.wdata, model_beat(a, cfg_seed));
        check_eq("wlast", axi.wlast, w_beat == BURST_LEN - 1);
        mem[a] = axi.wdata;
        if (!first_seen) begin first_wdata = axi.wdata; first_seen = 1; end
        w_beat++;
        if (w_beat == BURST_LEN) begin
          w_open = 0;
          b_pend = 1;
          b_resp = (w_burst_idx == cfg_slverr) ? 2'b10 : 2'b00;
          w_burst_idx++;
        end
      end
      prev_wstall = axi.wvalid && !axi.wready;
      prev_wdata  = axi.wdata;

      axi.awready = cfg_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (axi.awvalid && axi.awready) begin
        check_eq("awaddr", axi.awaddr, cfg_base + 64'(aw_n * BB));
        check_eq("aw_ctrl", {axi.awlen, axi.awsize, axi.awburst}, {8'd15, 3'b100, 2'b01});
        w_addr = axi.awaddr; w_beat = 0; w_open = 1; aw_n++;
      end

      if (r_hs || !r_open) axi.rvalid = 0;
      r_hs = 0;
      if (r_open) begin
        if (!axi.rvalid) axi.rvalid = cfg_bp ? 1'($urandom_range(0, 1)) : 1'b1;
        if (axi.rvalid) begin
          a = r_addr + 64'(r_beat * 16);
          d = mem.exists(a) ? mem[a] : '0;
          if (a == cfg_corrupt) d = d ^ 128'h1;
          axi.rdata = d;
          axi.rresp = 2'b00;
          axi.rlast = (r_beat == BURST_LEN - 1);
          if (axi.rready) begin
            r_hs = 1; r_beat++; r_beats++;
            if (r_beat == BURST_LEN) begin r_open = 0; last_r_cyc = cyc + 1; end
          end
        end
      end

      axi.arready = cfg_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (axi.arvalid && axi.arready) begin
        check_eq("araddr", axi.araddr, cfg_base + 64'(ar_n * BB));
        check_eq("ar_ctrl", {axi.arlen, axi.arsize, axi.arburst}, {8'd15, 3'b100, 2'b01});
        r_addr = axi.araddr; r_beat = 0; r_open = 1; ar_n++;
      end
    end
  end

  task automatic begin_run(input logic [63:0] base, input logic [15:0] num, input logic [31:0] sd,
                           input bit bp, input logic [63:0] corrupt, input int slverr);
    @(negedge clk);
    cfg_base = base & ~64'(BB - 1); cfg_seed = sd; cfg_bp = bp;
    cfg_corrupt = corrupt; cfg_slverr = slverr;
    aw_n = 0; ar_n = 0; r_beats = 0; w_burst_idx = 0; first_seen = 0;
    base_addr = base; num_bursts = num; seed = sd; start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic run_test(input string name, input logic [63:0] base, input logic [15:0] num,
                          input logic [31:0] sd, input bit bp, input logic [63:0] corrupt,
                          input int slverr, input bit poke);
    int          t;
    logic [15:0] exp_err;
    logic [63:0] exp_fail, cb;
    bit          exp_resp;
    begin_run(base, num, sd, bp, corrupt, slverr);
    if (num == 0) begin
      check_eq({name, "_done1"}, done, 1'b1);
      check_eq({name, "_pass1"}, pass, 1'b1);
      repeat (5) @(negedge clk);
      check_eq({name, "_no_aw"}, aw_n, 0);
      return;
    end
    check_eq({name, "_busy"}, busy, 1'b1);
    check_eq({name, "_clr"}, {resp_err, err_count, fail_addr}, '0);
    t = 0;
    while (!done && t < 20000) begin
      @(negedge clk);
      t++;
      if (poke && t == 40) begin
        base_addr = 64'hDEAD_BEE0; num_bursts = 16'd2; seed = ~sd; start = 1;
        @(negedge clk);
        start = 0; t++;
      end
    end
    check_eq({name, "_done"}, done, 1'b1);
    check_eq({name, "_done_lat"}, cyc, last_r_cyc);
    cb       = base & ~64'(BB - 1);
    exp_err  = (corrupt >= cb && corrupt < cb + 64'(int'(num) * BB)) ? 16'd1 : 16'd0;
    exp_fail = (exp_err != 0) ? corrupt : 64'd0;
    exp_resp = (slverr >= 0) && (slverr < int'(num));
    check_eq({name, "_err_count"}, err_count, exp_err);
    check_eq({name, "_fail_addr"}, fail_addr, exp_fail);
    check_eq({name, "_resp_err"}, resp_err, exp_resp);
    check_eq({name, "_pass"}, pass, (exp_err == 0) && !exp_resp);
    check_eq({name, "_bursts"}, {aw_n, ar_n}, {int'(num), int'(num)});
    check_eq({name, "_rbeats"}, r_beats, int'(num) * BURST_LEN);
  endtask

  initial begin
    int          t;
    logic [15:0] n;
    logic [63:0] b, c;
    repeat (3) @(negedge clk);
    check_eq("rst_status", {busy, done, pass, resp_err, err_count, fail_addr}, '0);
    check_eq("rst_axi", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, '0);
    rst_n = 1;

    run_test("basic", 64'h1000, 16'd4, 32'h0, 1'b0, '1, -1, 1'b0);
    check_eq("beat0_wdata", first_wdata, 128'h0000100C_00001008_00001004_00001000);
    run_test("corrupt", 64'h1000, 16'd4, 32'h0, 1'b0, 64'h1230, -1, 1'b0);
    run_test("backpressure", {32'h1, $urandom}, 16'd8, 32'hA5A5A5A5, 1'b1, '1, -1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      n = 16'($urandom_range(1, 6));
      b = {32'($urandom_range(0, 3)), $urandom};
      c = ($urandom_range(0, 1) != 0)
          ? (b & ~64'(BB - 1)) + 64'(16 * $urandom_range(0, int'(n) * BURST_LEN - 1)) : '1;
      run_test("random", b, n, $urandom, 1'b1, c, -1, 1'b0);
    end
    run_test("slverr", 64'h2000, 16'd4, 32'h1234_5678, 1'b1, '1, 2, 1'b0);
    run_test("restart_ignored", 64'h3000, 16'd5, 32'h0BAD_F00D, 1'b1, '1, -1, 1'b1);
    run_test("zero_bursts", 64'h4000, 16'd0, 32'h0, 1'b0, '1, -1, 1'b0);

    begin_run(64'h5000, 16'd4, 32'h55AA_55AA, 1'b1, '1, -1);
    t = 0;
    while (!axi.wvalid && t < 2000) begin @(negedge clk); t++; end
    check_eq("reach_wr_data", axi.wvalid, 1'b1);
    #2 rst_n = 0;
    #1;
    check_eq("arst_axi", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, '0);
    check_eq("arst_status", {busy, done, pass, resp_err, err_count, fail_addr}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    run_test("after_reset", 64'h6000, 16'd3, 32'hCAFE_0001, 1'b1, '1, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
